issue_window_core: RTL
======================

# issue_window_core

4-entry age-ordered issue window that sits directly upstream of the issue pick stage. It accepts one dispatched micro-op per cycle, tracks per-source readiness via writeback wakeup and the pick stage's ALU-forward hints, and presents flattened per-slot state to the picker. It removes the picked slot with in-order compaction, and flushes on snoop hit or branch correction.

## Interface
- No parameters; depth fixed at 4, ROB tag 4 bits.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `snoop_hit` in 1: flush all entries.
- `bco_valid` in 1: branch-correction flush, same effect as `snoop_hit`.
- `d_valid` in 1: dispatch request.
- `d_ready` out 1: window can accept this cycle.
- `d_src0_rob`, `d_src1_rob`, `d_dst_rob` in 4 each: source and destination ROB tags.
- `d_src0_rdy`, `d_src1_rdy` in 1 each: source ready at dispatch.
- `d_branch`, `d_load`, `d_store` in 1 each: class flags.
- `d_pipe_alu`, `d_pipe_mul`, `d_pipe_mem`, `d_pipe_bru` in 1 each: pipe select, one-hot.
- `wb_valid` in 1: writeback wakeup broadcast.
- `wb_rob` in 4: tag being written back.
- `pick_en` in 4: one-hot or zero from the picker; the slot is consumed this cycle.
- `pick_fwd_src0`, `pick_fwd_src1` in 4 each: per-slot ALU-forward hit from the picker.
- `o_valid` out 4: per-slot valid. Slot 0 is oldest.
- `o_src0_rob`, `o_src1_rob`, `o_dst_rob` out 16 each: slot j at bits [4j+3:4j].
- `o_src0_rdy`, `o_src1_rdy` out 4 each.
- `o_branch`, `o_load`, `o_store` out 4 each.
- `o_pipe_alu`, `o_pipe_mul`, `o_pipe_mem`, `o_pipe_bru` out 4 each.
- `o_count` out 3: occupancy, 0..4.

## Operation
- All `o_*` outputs are registers. On `reset` they all clear to 0 and `o_count` = 0.
- Entries are kept contiguous from slot 0. Valid slots are exactly [0, `o_count`-1].
- Per-cycle update order is compute-then-commit; all of the following happen in one edge:
  1. **Wakeup.** For every valid slot, `srcX_rdy` is set if it is already set, or (`wb_valid` and `srcX_rob` == `wb_rob`), or `pick_fwd_srcX[j]`. Readiness never clears except when the slot is freed.
  2. **Removal.** If `pick_en[k]`, slot k is freed. Slots k+1..3 shift down by one, carrying their woken state. A `pick_en` bit on an invalid slot is a protocol error; it is ignored and does not decrement `o_count`.
  3. **Insert.** If `d_valid & d_ready`, the new entry is written at index (count after removal). Its src rdy bits are ORed with the same-cycle `wb_valid`/`wb_rob` match. Forward hints do not apply to a new entry.
- `d_ready` = ~flush & (`o_count` != 4), where flush = `snoop_hit` | `bco_valid`. It is combinational from registered count and the flush inputs only.
- **Flush.** Flush has priority over everything. All `o_valid` and rdy bits clear and `o_count` becomes 0. Dispatch and pick in the flush cycle are discarded.
- The picker guarantees `pick_en` is zero when `o_valid` is zero. The window does not re-check fences.

## Timing
- A dispatch accepted at edge N is visible on `o_*` after edge N. It is pickable in cycle N+1 at the earliest.
- Wakeup latency: a `wb_valid` in cycle N sets rdy after edge N. This includes an entry being dispatched in cycle N.
- A forward hint in cycle N is latched into rdy at edge N. The slot can still be picked in cycle N through the picker's own bypass.
- Pick consumption and compaction complete at the same edge; there is no bubble.
- Simultaneous pick and dispatch at full: `d_ready` = 0 (see Configuration).
- If `reset` is asserted mid-operation, all state clears immediately (asynchronous). Normal operation resumes on the first edge after deassertion.

## Configuration
- `ISSUE_WINDOW_FULL_BYPASS_EN`
  - Defined: `d_ready` = ~flush & ((`o_count` != 4) | (|`pick_en`)). A full window accepts a dispatch in the same cycle it releases a slot, and the new entry lands in slot 3.
  - Undefined: `d_ready` follows the Operation rule, with no combinational path from `pick_en`.

## Test plan
- Reset, then 4 back-to-back dispatches with dst 1,2,3,4 -> `o_count` 1,2,3,4; `d_ready` = 0 at count 4; `o_dst_rob` = 0x4321.
- Full window, `pick_en` = 0010 -> after the edge, `o_dst_rob` = 0x0431, `o_count` = 3, and the slot-2/3 rdy bits move to slots 1/2.
- Slot 2 has src0 = 7 with rdy 0; `wb_valid` = 1, `wb_rob` = 7 in the same cycle as a dispatch whose src1 = 7 with rdy 0 -> both rdy bits are 1 after the edge.
- `pick_fwd_src1` = 0001 with slot 0 src1 not ready and no pick -> `o_src1_rdy[0]` = 1 next cycle.
- Count 3, with dispatch, pick, and `bco_valid` all asserted in one cycle -> `o_count` = 0 and `o_valid` = 0000; in the next cycle `d_ready` = 1.
- With `ISSUE_WINDOW_FULL_BYPASS_EN` defined: full window, `pick_en` = 0001 plus dispatch with dst = 9 -> `d_ready` = 1, `o_count` stays 4, and `o_dst_rob[15:12]` = 9. Without the macro: `d_ready` = 0 and `o_count` = 3.

Source files
------------

// File: rtl/issue_window_core.sv
// issue_window_core: 4-entry age-ordered issue window. Slot 0 holds the oldest entry and valid slots are always contiguous.
// Latency: a dispatch accepted at edge N is visible after edge N. Wakeup, pick removal and compaction all land on the same edge.
// Backpressure: d_ready drops when the window is full or a flush is active. ISSUE_WINDOW_FULL_BYPASS_EN lets a full window accept a dispatch in a cycle that also picks.
// Ports:
//   clk, reset (async, active-high); snoop_hit, bco_valid: flush inputs
//   d_*  : dispatch request/handshake and micro-op fields
//   wb_* : writeback wakeup broadcast; pick_en / pick_fwd_*: picker consumption and forward hints
//   o_*  : registered per-slot state, slot j at bits [4j+3:4j] for tags; o_count = occupancy
module issue_window_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        snoop_hit,
  input  logic        bco_valid,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [3:0]  d_src0_rob,
  input  logic [3:0]  d_src1_rob,
  input  logic [3:0]  d_dst_rob,
  input  logic        d_src0_rdy,
  input  logic        d_src1_rdy,
  input  logic        d_branch,
  input  logic        d_load,
  input  logic        d_store,
  input  logic        d_pipe_alu,
  input  logic        d_pipe_mul,
  input  logic        d_pipe_mem,
  input  logic        d_pipe_bru,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rob,
  input  logic [3:0]  pick_en,
  input  logic [3:0]  pick_fwd_src0,
  input  logic [3:0]  pick_fwd_src1,
  output logic [3:0]  o_valid,
  output logic [15:0] o_src0_rob,
  output logic [15:0] o_src1_rob,
  output logic [15:0] o_dst_rob,
  output logic [3:0]  o_src0_rdy,
  output logic [3:0]  o_src1_rdy,
  output logic [3:0]  o_branch,
  output logic [3:0]  o_load,
  output logic [3:0]  o_store,
  output logic [3:0]  o_pipe_alu,
  output logic [3:0]  o_pipe_mul,
  output logic [3:0]  o_pipe_mem,
  output logic [3:0]  o_pipe_bru,
  output logic [2:0]  o_count
);

  typedef struct packed {
    logic [3:0] src0;
    logic [3:0] src1;
    logic [3:0] dst;
    logic       src0_rdy;
    logic       src1_rdy;
    logic       branch;
    logic       load;
    logic       store;
    logic       alu;
    logic       mul;
    logic       mem;
    logic       bru;
  } ent_t;

  ent_t       r_ent [4];
  logic [3:0] r_valid;
  logic [2:0] r_count;

  logic       w_flush;
  logic       w_accept;
  logic [3:0] w_pick_vld;
  logic       w_pick_hit;
  logic [1:0] w_pick_idx;
  logic [2:0] w_cnt_rm;
  logic [2:0] w_cnt_next;
  logic [3:0] w_valid_next;
  ent_t       w_new;
  ent_t       w_woke [5];
  ent_t       w_next [4];

  assign w_flush = snoop_hit | bco_valid;

`ifdef ISSUE_WINDOW_FULL_BYPASS_EN
  // A full window can only pick a valid slot, so any pick frees room for the dispatch.
  assign d_ready = ~w_flush & ((r_count != 3'd4) | (|pick_en));
`else
  assign d_ready = ~w_flush & (r_count != 3'd4);
`endif

  assign w_accept   = d_valid & d_ready;
  // Picks on empty slots are dropped so they cannot corrupt the count.
  assign w_pick_vld = pick_en & r_valid;
  assign w_pick_hit = |w_pick_vld;
  assign w_cnt_rm   = r_count - {2'b00, w_pick_hit};
  assign w_cnt_next = w_cnt_rm + {2'b00, w_accept};

  // Wakeup on the current slots. Invalid slots are held at zero and must stay that way.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_woke[j] = r_ent[j];
      if (r_valid[j]) begin
        if (pick_fwd_src0[j] | (wb_valid & (r_ent[j].src0 == wb_rob))) w_woke[j].src0_rdy = 1'b1;
        if (pick_fwd_src1[j] | (wb_valid & (r_ent[j].src1 == wb_rob))) w_woke[j].src1_rdy = 1'b1;
      end
    end
    // Zero entry that shifts into the top slot on removal.
    w_woke[4] = '0;
  end

  always_comb begin
    w_pick_idx = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (w_pick_vld[j]) w_pick_idx = 2'(j);
    end
  end

  // The new entry sees the same-cycle writeback but not forward hints.
  always_comb begin
    w_new          = '0;
    w_new.src0     = d_src0_rob;
    w_new.src1     = d_src1_rob;
    w_new.dst      = d_dst_rob;
    w_new.src0_rdy = d_src0_rdy | (wb_valid & (d_src0_rob == wb_rob));
    w_new.src1_rdy = d_src1_rdy | (wb_valid & (d_src1_rob == wb_rob));
    w_new.branch   = d_branch;
    w_new.load     = d_load;
    w_new.store    = d_store;
    w_new.alu      = d_pipe_alu;
    w_new.mul      = d_pipe_mul;
    w_new.mem      = d_pipe_mem;
    w_new.bru      = d_pipe_bru;
  end

  // Compaction, then insert at the post-removal tail.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      if (w_pick_hit && (2'(j) >= w_pick_idx)) w_next[j] = w_woke[j+1];
      else                                     w_next[j] = w_woke[j];
      if (w_accept && (w_cnt_rm == 3'(j)))     w_next[j] = w_new;
      w_valid_next[j] = (3'(j) < w_cnt_next);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 4; j++) r_ent[j] <= '0;
      r_valid <= 4'b0000;
      r_count <= 3'd0;
    end else if (w_flush) begin
      for (int j = 0; j < 4; j++) r_ent[j] <= '0;
      r_valid <= 4'b0000;
      r_count <= 3'd0;
    end else begin
      for (int j = 0; j < 4; j++) r_ent[j] <= w_next[j];
      r_valid <= w_valid_next;
      r_count <= w_cnt_next;
    end
  end

  assign o_valid = r_valid;
  assign o_count = r_count;

  for (genvar g = 0; g < 4; g++) begin : g_flat
    assign o_src0_rob[4*g +: 4] = r_ent[g].src0;
    assign o_src1_rob[4*g +: 4] = r_ent[g].src1;
    assign o_dst_rob[4*g +: 4]  = r_ent[g].dst;
    assign o_src0_rdy[g]        = r_ent[g].src0_rdy;
    assign o_src1_rdy[g]        = r_ent[g].src1_rdy;
    assign o_branch[g]          = r_ent[g].branch;
    assign o_load[g]            = r_ent[g].load;
    assign o_store[g]           = r_ent[g].store;
    assign o_pipe_alu[g]        = r_ent[g].alu;
    assign o_pipe_mul[g]        = r_ent[g].mul;
    assign o_pipe_mem[g]        = r_ent[g].mem;
    assign o_pipe_bru[g]        = r_ent[g].bru;
  end

endmodule
